rs_issue_scheduler: RTL and testbench

Control half of the reservation station (RS): owns per-slot busy bits, operand-pending flags and relative age for `RS_SIZE` slots. It picks the slot the decoder writes on dispatch, wakes slots on CDB broadcasts, and issues the oldest ready slot to the ALU over a valid/ready handshake. It also empties the station on a branch-mispredict clear. The RS payload array indexes its storage with `alloc_line` and `issue_line` from this block.

---
 rtl/rs_issue_scheduler_pkg.sv | 6 +
 rtl/rs_lowbit_encoder.sv | 16 +
 rtl/rs_issue_scheduler.sv | 108 ++++++++++
 tb/tb_rs_issue_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs_issue_scheduler_pkg.sv
// rs_issue_scheduler_pkg: shared RS/ROB sizing for the issue scheduler slice
package rs_issue_scheduler_pkg;
  localparam int RS_SIZE_DFLT = 16;
  localparam int RS_SIZE_WIDTH_DFLT = 4;
  localparam int ROB_SIZE_WIDTH_DFLT = 5;
endpackage

// File: rtl/rs_lowbit_encoder.sv
// rs_lowbit_encoder: index of lowest set bit of vec_i on idx_o (0 if none), valid_o when any bit set
module rs_lowbit_encoder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec_i[i]) idx_o = W'(i);
  end
  assign valid_o = |vec_i;
endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: RS control (busy/pending/age per slot); ports: clk, rst (sync active-low), rdy, clear, disp_* in, cdb_* in, alu_ready in; rs_full, alloc_line, issue_* , busy, ready out
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DFLT,
  parameter int RS_SIZE_WIDTH = RS_SIZE_WIDTH_DFLT,
  parameter int ROB_SIZE_WIDTH = ROB_SIZE_WIDTH_DFLT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      disp_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_rob_id,
  input  logic                      disp_qj_pend,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_qj,
  input  logic                      disp_qk_pend,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_qk,
  input  logic                      cdb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id,
  input  logic                      alu_ready,
  output logic                      rs_full,
  output logic [RS_SIZE_WIDTH-1:0]  alloc_line,
  output logic                      issue_valid,
  output logic [RS_SIZE_WIDTH-1:0]  issue_line,
  output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  output logic [RS_SIZE-1:0]        busy,
  output logic [RS_SIZE-1:0]        ready
);
  logic [RS_SIZE-1:0] busy_q, busy_d, qj_pend_q, qj_pend_d, qk_pend_q, qk_pend_d, blocked;
  logic [ROB_SIZE_WIDTH-1:0] qj_q [RS_SIZE], qj_d [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] qk_q [RS_SIZE], qk_d [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] rob_q [RS_SIZE], rob_d [RS_SIZE];
  logic [RS_SIZE-1:0] older_q [RS_SIZE], older_d [RS_SIZE];
  logic free_v, disp_fire, issue_fire;
  assign busy = busy_q;
  assign ready = busy_q & ~qj_pend_q & ~qk_pend_q;
  assign rs_full = ~free_v;
  rs_lowbit_encoder #(.N(RS_SIZE), .W(RS_SIZE_WIDTH)) u_free (
    .vec_i(~busy_q),
    .idx_o(alloc_line),
    .valid_o(free_v)
  );
  // a ready slot is blocked when any other ready slot is older; the age order is total, so one survives
  always_comb begin
    blocked = '0;
    issue_line = '0;
    for (int i = 0; i < RS_SIZE; i++)
      for (int j = 0; j < RS_SIZE; j++)
        blocked[i] = blocked[i] | (ready[j] & older_q[j][i]);
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (ready[i] && !blocked[i]) issue_line = RS_SIZE_WIDTH'(i);
  end
  assign issue_valid = |ready;
  assign issue_rob_id = issue_valid ? rob_q[issue_line] : '0;
  assign disp_fire = disp_valid & free_v;
  assign issue_fire = issue_valid & alu_ready;
  always_comb begin
    busy_d = busy_q;
    qj_pend_d = qj_pend_q;
    qk_pend_d = qk_pend_q;
    qj_d = qj_q;
    qk_d = qk_q;
    rob_d = rob_q;
    older_d = older_q;
    if (clear) begin
      busy_d = '0;
      for (int i = 0; i < RS_SIZE; i++) older_d[i] = '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (cdb_valid && qj_q[i] == cdb_rob_id) qj_pend_d[i] = 1'b0;
        if (cdb_valid && qk_q[i] == cdb_rob_id) qk_pend_d[i] = 1'b0;
      end
      if (disp_fire) begin
        busy_d[alloc_line] = 1'b1;
        qj_pend_d[alloc_line] = disp_qj_pend && !(cdb_valid && disp_qj == cdb_rob_id);
        qk_pend_d[alloc_line] = disp_qk_pend && !(cdb_valid && disp_qk == cdb_rob_id);
        qj_d[alloc_line] = disp_qj;
        qk_d[alloc_line] = disp_qk;
        rob_d[alloc_line] = disp_rob_id;
        older_d[alloc_line] = '0;
        for (int j = 0; j < RS_SIZE; j++) older_d[j][alloc_line] = busy_q[j];
      end
      // applied after dispatch so the issued slot drops out of the new slot's column too
      if (issue_fire) begin
        busy_d[issue_line] = 1'b0;
        older_d[issue_line] = '0;
        for (int j = 0; j < RS_SIZE; j++) older_d[j][issue_line] = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      qj_pend_q <= '0;
      qk_pend_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
      qj_pend_q <= qj_pend_d;
      qk_pend_q <= qk_pend_d;
      qj_q <= qj_d;
      qk_q <= qk_d;
      rob_q <= rob_d;
      older_q <= older_d;
    end
  end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: scoreboard bench with a dispatch-sequence reference model of the RS scheduler
module tb_rs_issue_scheduler;
  localparam int N = 16;
  localparam int W = 4;
  localparam int R = 5;
  logic clk, rst, rdy, clear, disp_valid, disp_qj_pend, disp_qk_pend, cdb_valid, alu_ready;
  logic [R-1:0] disp_rob_id, disp_qj, disp_qk, cdb_rob_id;
  logic rs_full, issue_valid;
  logic [W-1:0] alloc_line, issue_line;
  logic [R-1:0] issue_rob_id;
  logic [N-1:0] busy, ready;
  rs_issue_scheduler #(.RS_SIZE(N), .RS_SIZE_WIDTH(W), .ROB_SIZE_WIDTH(R)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .disp_valid(disp_valid), .disp_rob_id(disp_rob_id),
    .disp_qj_pend(disp_qj_pend), .disp_qj(disp_qj),
    .disp_qk_pend(disp_qk_pend), .disp_qk(disp_qk),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .alu_ready(alu_ready),
    .rs_full(rs_full), .alloc_line(alloc_line), .issue_valid(issue_valid),
    .issue_line(issue_line), .issue_rob_id(issue_rob_id), .busy(busy), .ready(ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic full;
    logic [W-1:0] alloc;
    logic iv;
    logic [W-1:0] il;
    logic [R-1:0] ir;
    logic [N-1:0] busy;
    logic [N-1:0] ready;
  } exp_t;
  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;
  // model: each slot remembers the order it was dispatched in; oldest = smallest sequence number
  bit m_busy[N], m_jp[N], m_kp[N];
  logic [R-1:0] m_j[N], m_k[N], m_rob[N];
  int m_seq[N];
  int seq_ctr = 0;
  function automatic exp_t model_out();
    exp_t o;
    int best = -1;
    o.full = 1'b1;
    o.alloc = '0;
    o.busy = '0;
    o.ready = '0;
    for (int i = N - 1; i >= 0; i--) begin
      o.busy[i] = m_busy[i];
      o.ready[i] = m_busy[i] && !m_jp[i] && !m_kp[i];
      if (!m_busy[i]) begin
        o.full = 1'b0;
        o.alloc = W'(i);
      end
    end
    for (int i = 0; i < N; i++)
      if (o.ready[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
    o.iv = best >= 0;
    o.il = o.iv ? W'(best) : '0;
    o.ir = o.iv ? m_rob[best] : '0;
    return o;
  endfunction
  task automatic model_edge();
    exp_t o;
    o = model_out();
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 0;
        m_jp[i] = 0;
        m_kp[i] = 0;
      end
    end else if (rdy) begin
      if (clear) begin
        for (int i = 0; i < N; i++) m_busy[i] = 0;
      end else begin
        for (int i = 0; i < N; i++)
          if (m_busy[i] && cdb_valid) begin
            if (m_j[i] == cdb_rob_id) m_jp[i] = 0;
            if (m_k[i] == cdb_rob_id) m_kp[i] = 0;
          end
        if (disp_valid && !o.full) begin
          m_busy[o.alloc] = 1;
          m_jp[o.alloc] = disp_qj_pend && !(cdb_valid && disp_qj == cdb_rob_id);
          m_kp[o.alloc] = disp_qk_pend && !(cdb_valid && disp_qk == cdb_rob_id);
          m_j[o.alloc] = disp_qj;
          m_k[o.alloc] = disp_qk;
          m_rob[o.alloc] = disp_rob_id;
          m_seq[o.alloc] = seq_ctr;
          seq_ctr++;
        end
        if (o.iv && alu_ready) m_busy[o.il] = 0;
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    sbq.push_back(model_out());
  endtask
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rs_full", 32'(rs_full), 32'(e.full));
      chk("alloc_line", 32'(alloc_line), 32'(e.alloc));
      chk("issue_valid", 32'(issue_valid), 32'(e.iv));
      chk("issue_line", 32'(issue_line), 32'(e.il));
      chk("issue_rob_id", 32'(issue_rob_id), 32'(e.ir));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("ready", 32'(ready), 32'(e.ready));
    end
  end
  task automatic idle();
    clear = 0;
    disp_valid = 0;
    cdb_valid = 0;
    alu_ready = 0;
  endtask
  task automatic disp(int rob, bit jp, int j, bit kp, int k);
    disp_valid = 1;
    disp_rob_id = R'(rob);
    disp_qj_pend = jp;
    disp_qj = R'(j);
    disp_qk_pend = kp;
    disp_qk = R'(k);
  endtask
  initial begin
    rst = 0;
    rdy = 1;
    idle();
    disp(0, 0, 0, 0, 0);
    disp_valid = 0;
    cdb_rob_id = '0;
    step();
    step();
    rst = 1;
    alu_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      disp(i, 0, 0, 0, 0);
      step();
    end
    disp_valid = 0;
    repeat (4) step();
    alu_ready = 0;
    for (int i = 0; i < 17; i++) begin
      disp(i + 8, 1, 7, 0, 0);
      step();
    end
    disp_valid = 0;
    cdb_valid = 1;
    cdb_rob_id = 7;
    step();
    cdb_valid = 0;
    alu_ready = 1;
    repeat (17) step();
    alu_ready = 0;
    disp(20, 1, 5, 0, 0);
    cdb_valid = 1;
    cdb_rob_id = 5;
    step();
    idle();
    step();
    alu_ready = 1;
    repeat (2) step();
    alu_ready = 0;
    disp(11, 1, 9, 0, 0);
    step();
    disp(12, 0, 0, 1, 9);
    step();
    disp_valid = 0;
    cdb_valid = 1;
    cdb_rob_id = 9;
    step();
    cdb_valid = 0;
    repeat (3) step();
    alu_ready = 1;
    repeat (3) step();
    alu_ready = 0;
    for (int i = 0; i < 5; i++) begin
      disp(i, 0, 0, 0, 0);
      step();
    end
    clear = 1;
    disp(30, 0, 0, 0, 0);
    alu_ready = 1;
    step();
    idle();
    step();
    for (int i = 0; i < 3; i++) begin
      disp(i + 1, 1, 3, 0, 0);
      step();
    end
    rdy = 0;
    cdb_valid = 1;
    cdb_rob_id = 3;
    alu_ready = 1;
    disp(9, 0, 0, 0, 0);
    repeat (2) step();
    rdy = 1;
    step();
    idle();
    step();
    rst = 0;
    step();
    rst = 1;
    step();
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 199) != 0;
      rdy = $urandom_range(0, 9) != 0;
      clear = $urandom_range(0, 49) == 0;
      disp_valid = $urandom_range(0, 2) != 0;
      disp_rob_id = R'($urandom);
      disp_qj_pend = $urandom_range(0, 1) == 1;
      disp_qj = R'($urandom_range(0, 7));
      disp_qk_pend = $urandom_range(0, 2) == 0;
      disp_qk = R'($urandom_range(0, 7));
      cdb_valid = $urandom_range(0, 1) == 1;
      cdb_rob_id = R'($urandom_range(0, 7));
      alu_ready = $urandom_range(0, 2) == 0;
      step();
    end
    idle();
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
